// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Pipelined bitwise logic unit. Each accepted beat selects one of eight
//   bitwise operations on in_a/in_b. The result and its zero / all-ones /
//   parity flags are carried through an elastic valid/ready pipeline of PIPE
//   register stages (1 = result register only, 2 = operand register plus
//   result register). Full throughput is one beat per cycle. Beats leave in
//   strict FIFO order, and none are dropped or duplicated under backpressure.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   PIPE   number of register stages, 1 or 2
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of every in-flight beat (input beat discarded)
//   in_valid   operand beat valid
//   in_ready   unit accepts a beat this cycle (combinational)
//   in_op      op select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR,
//              101 XNOR, 110 ANDN (a & ~b), 111 PASS_A
//   in_a/in_b  operands
//   out_valid  result beat valid
//   out_ready  downstream accepts result
//   out_res    result
//   out_zero   out_res == 0
//   out_ones   out_res == all ones
//   out_par    XOR-reduce of out_res
//   out_cnt    number of ones in out_res (only with LOGIC_UNIT_POPCNT_EN)
//
// Configuration
//   LOGIC_UNIT_POPCNT_EN  when defined, adds the out_cnt port and the
//                         registered popcount of the result.
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 64,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_ones,
`ifdef LOGIC_UNIT_POPCNT_EN
  output logic [$clog2(WIDTH+1)-1:0] out_cnt,
`endif
  output logic             out_par
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      OP_PASS: r = a;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic f_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

`ifdef LOGIC_UNIT_POPCNT_EN
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [CW-1:0] f_popcnt(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(CW-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Configuration check
  // ---------------------------------------------------------------------------
  generate
    if ((PIPE != 1) && (PIPE != 2)) begin : g_bad_pipe
      $error("logic_unit_pipe: PIPE must be 1 or 2");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Result stage state and the source that feeds it
  // ---------------------------------------------------------------------------
  logic             out_valid_r;
  logic [WIDTH-1:0] res_r;
  logic             zero_r;
  logic             ones_r;
  logic             par_r;

  logic             out_free_s;   // result stage is empty or drains this cycle
  logic             in_ready_s;
  logic             src_valid_s;  // beat offered to the result stage
  logic [2:0]       src_op_s;
  logic [WIDTH-1:0] src_a_s;
  logic [WIDTH-1:0] src_b_s;

  logic [WIDTH-1:0] res_s;
  logic             zero_s;
  logic             ones_s;
  logic             par_s;

  assign out_free_s = ~out_valid_r | out_ready;

  generate
    if (PIPE == 2) begin : g_pipe2
      logic             s1_valid_r;
      logic [2:0]       s1_op_r;
      logic [WIDTH-1:0] s1_a_r;
      logic [WIDTH-1:0] s1_b_r;

      // Operand stage loads when empty or when its beat moves on this cycle.
      assign in_ready_s = ~s1_valid_r | out_free_s;

      // Operand register stage: valid bit plus captured op/operands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_r <= 1'b0;
          s1_op_r    <= 3'b000;
          s1_a_r     <= {WIDTH{1'b0}};
          s1_b_r     <= {WIDTH{1'b0}};
        end else if (flush) begin
          s1_valid_r <= 1'b0;
        end else if (in_ready_s) begin
          s1_valid_r <= in_valid;
          // Payload only moves with a real beat so idle cycles never disturb it.
          if (in_valid) begin
            s1_op_r <= in_op;
            s1_a_r  <= in_a;
            s1_b_r  <= in_b;
          end
        end
      end

      assign src_valid_s = s1_valid_r;
      assign src_op_s    = s1_op_r;
      assign src_a_s     = s1_a_r;
      assign src_b_s     = s1_b_r;
    end else begin : g_pipe1
      // Single stage: the input beat feeds the result register directly.
      assign in_ready_s  = out_free_s;
      assign src_valid_s = in_valid;
      assign src_op_s    = in_op;
      assign src_a_s     = in_a;
      assign src_b_s     = in_b;
    end
  endgenerate

  // Flags are derived from the result in the same stage, so they stay aligned.
  assign res_s  = f_logic_op(src_op_s, src_a_s, src_b_s);
  assign zero_s = (res_s == {WIDTH{1'b0}});
  assign ones_s = &res_s;
  assign par_s  = f_parity(res_s);

  // Result register stage: valid bit plus result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      res_r       <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      ones_r      <= 1'b0;
      par_r       <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (out_free_s) begin
      out_valid_r <= src_valid_s;
      // Hold result/flags when no beat arrives so outputs never glitch.
      if (src_valid_s) begin
        res_r  <= res_s;
        zero_r <= zero_s;
        ones_r <= ones_s;
        par_r  <= par_s;
      end
    end
  end

`ifdef LOGIC_UNIT_POPCNT_EN
  logic [CW-1:0] cnt_r;

  // Popcount register, loaded in lockstep with the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (!flush && out_free_s && src_valid_s) begin
      cnt_r <= f_popcnt(res_s);
    end
  end

  assign out_cnt = cnt_r;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_res   = res_r;
  assign out_zero  = zero_r;
  assign out_ones  = ones_r;
  assign out_par   = par_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Self-checking bench for logic_unit_pipe (WIDTH=64, PIPE=2). Expected
//   results are pushed to a scoreboard queue when a beat is accepted and are
//   popped and compared when the unit delivers a result.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  localparam int WIDTH = 64;
  localparam int PIPE  = 2;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;
  logic             out_ones;
  logic             out_par;
`ifdef LOGIC_UNIT_POPCNT_EN
  logic [CW-1:0]    out_cnt;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ones;
    logic             par;
    logic [CW-1:0]    cnt;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rx_count    = 0;
  logic last_acc    = 1'b0;

  logic_unit_pipe #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_ones  (out_ones),
`ifdef LOGIC_UNIT_POPCNT_EN
    .out_cnt   (out_cnt),
`endif
    .out_par   (out_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written straight from the op table.
  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH-1:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = a & ~b;
      default: r = a;
    endcase
    e.res  = r;
    e.zero = (r == {WIDTH{1'b0}});
    e.ones = (r == {WIDTH{1'b1}});
    e.par  = ^r;
    e.cnt  = CW'($countones(r));
    return e;
  endfunction

  // Scoreboard: called at the falling edge, ahead of the rising edge.
  task automatic sb_check();
    exp_t e;
    last_acc = in_valid && in_ready && !flush;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        rx_count++;
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got res=%h with no beat outstanding", out_res);
        end else begin
          e = sb_q.pop_front();
          if ({out_res, out_zero, out_ones, out_par} !== {e.res, e.zero, e.ones, e.par}) begin
            miscompares++;
            $display("FAIL sb_result: got res=%h z=%b o=%b p=%b, expected res=%h z=%b o=%b p=%b",
                     out_res, out_zero, out_ones, out_par, e.res, e.zero, e.ones, e.par);
          end
`ifdef LOGIC_UNIT_POPCNT_EN
          vectors++;
          if (out_cnt !== e.cnt) begin
            miscompares++;
            $display("FAIL sb_cnt: got %0d, expected %0d", out_cnt, e.cnt);
          end
`endif
        end
      end
      if (flush) sb_q.delete();
      else if (last_acc) sb_q.push_back(model(in_op, in_a, in_b));
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    do begin
      step();
      n++;
    end while (!last_acc && n < 100);
    in_valid = 1'b0;
    if (!last_acc) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: beat not accepted in %0d cycles, required acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 3'd0; in_a = '0; in_b = '0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_res, out_zero, out_ones, out_par} !== {(WIDTH+4){1'b0}}) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b res=%h z=%b o=%b p=%b, required all 0",
               out_valid, out_res, out_zero, out_ones, out_par);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_walk();
    logic [WIDTH-1:0] one_hot;
    for (int i = 0; i < WIDTH; i++) begin
      one_hot = '0;
      one_hot[i] = 1'b1;
      for (int op = 0; op < 8; op++) begin
        send(3'(op), one_hot, {WIDTH{1'b0}});
        send(3'(op), one_hot, {WIDTH{1'b1}});
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int rx0;
    drain();
    rx0 = rx_count;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_op = 3'($urandom_range(0, 7));
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      step();
      vectors++;
      if (last_acc !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_accept: beat %0d accepted=%b, required 1", k, last_acc);
      end
      if (k == 0 || k == 1) begin
        vectors++;
        if (out_valid !== (k == 1)) begin
          miscompares++;
          $display("FAIL b2b_latency: cycle %0d out_valid=%b, required %b", k, out_valid, (k == 1));
        end
      end
    end
    drain();
    vectors++;
    if (rx_count - rx0 != 16) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results, required 16", rx_count - rx0);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]       ops [12];
    logic [WIDTH-1:0] as_ [12];
    logic [WIDTH-1:0] bs_ [12];
    logic [WIDTH-1:0] held;
    int idx, c, rx0;
    for (int k = 0; k < 12; k++) begin
      ops[k] = 3'($urandom_range(0, 7));
      as_[k] = {$urandom, $urandom};
      bs_[k] = {$urandom, $urandom};
    end
    idx = 0; c = 0; rx0 = rx_count; held = '0;
    while (idx < 12 && c < 60) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid = 1'b1; in_op = ops[idx]; in_a = as_[idx]; in_b = bs_[idx];
      if (c == 4) held = out_res;
      step();
      if (last_acc) idx++;
      if (c >= 4 && c < 9) begin
        vectors++;
        if (out_valid !== 1'b1 || out_res !== held) begin
          miscompares++;
          $display("FAIL bp_hold: cycle %0d v=%b res=%h, required v=1 res=%h", c, out_valid, out_res, held);
        end
      end
      if (c == 8) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_in_ready: got %b with pipe full, required 0", in_ready);
        end
      end
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (idx < 12) begin
      vectors++; miscompares++;
      $display("FAIL bp_timeout: %0d beats accepted, required 12", idx);
    end
    drain();
    vectors++;
    if (rx_count - rx0 != 12) begin
      miscompares++;
      $display("FAIL bp_count: got %0d results, required 12", rx_count - rx0);
    end
  endtask

  task automatic test_flush();
    drain();
    out_ready = 1'b0;
    send(3'd2, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F);
    send(3'd1, 64'h00FF_0000_0000_0000, 64'h0000_0000_0000_00FF);
    // Flush with a beat presented: both in-flight beats and this beat vanish.
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd7; in_a = 64'hDEAD_BEEF_0000_0001; in_b = '0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_clear: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd6; in_a = 64'hFFFF_0000_FFFF_0000; in_b = 64'hFF00_FF00_FF00_FF00;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_lat1: got out_valid=%b one cycle after accept, required 0", out_valid);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || sb_q.size() != 1) begin
      miscompares++;
      $display("FAIL flush_lat2: got out_valid=%b queue=%0d, required 1/1", out_valid, sb_q.size());
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    int rx0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = 3'($urandom_range(0, 6));
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_res, out_zero, out_ones, out_par} !== {(WIDTH+4){1'b0}}) begin
      miscompares++;
      $display("FAIL midreset_outputs: got v=%b res=%h z=%b o=%b p=%b, required all 0",
               out_valid, out_res, out_zero, out_ones, out_par);
    end
`ifdef LOGIC_UNIT_POPCNT_EN
    vectors++;
    if (out_cnt !== {CW{1'b0}}) begin
      miscompares++;
      $display("FAIL midreset_cnt: got %0d, required 0", out_cnt);
    end
`endif
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    rx0 = rx_count;
    for (int k = 0; k < 4; k++) step();
    vectors++;
    if (rx_count != rx0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_quiet: got %0d results in_ready=%b, required 0 results in_ready=1",
               rx_count - rx0, in_ready);
    end
`ifdef LOGIC_UNIT_POPCNT_EN
    send(3'd1, 64'h0000_0000_0000_000F, 64'h0);
    drain();
    vectors++;
    if (out_cnt !== CW'(4)) begin
      miscompares++;
      $display("FAIL popcnt_0f: got %0d, required 4", out_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_walk();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
